// File: rtl/calc_entry_sequencer_pkg.sv
// Shared types for the calculator entry sequencer: FSM states, operator codes, widths.
package calc_pkg;

  localparam int OPERAND_W_DEF = 5;
  localparam int RESULT_W      = 8;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_CALC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

endpackage

// File: rtl/calc_entry_sequencer_debounce.sv
// btn_debounce: 2-flop synchronizer, stability counter and one-cycle press pulse
// on each accepted rising edge of a raw async button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      // Any return to the accepted level restarts the stability window.
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync_p1;
        cnt   <= '0;
        press <= sync_p1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/calc_entry_sequencer.sv
// calc_entry_sequencer: operand/operator entry FSM with calculator start/done handshake and timeout.
// Optional macro CALC_CHAIN_EN: ENTER in S_SHOW reloads operand_a from the result for chaining.
module calc_entry_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int OPERAND_W       = OPERAND_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPERAND_W-1:0] sw_data,
  input  logic                 btn_enter,
  input  logic                 btn_clear,
  input  logic [RESULT_W-1:0]  result,
  input  logic                 sign,
  input  logic                 calc_done,
  output logic [OPERAND_W-1:0] operand_a,
  output logic [OPERAND_W-1:0] operand_b,
  output logic [1:0]           operator,
  output logic                 calc_start,
  output logic                 result_valid,
  output logic                 calc_error,
  output logic [2:0]           state_code
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t               state, state_nxt;
  logic                 enter_p, clear_p;
  logic [TW-1:0]        tmo_cnt;
  logic                 tmo_hit;
  logic [OPERAND_W-1:0] a_nxt, b_nxt;
  logic [1:0]           op_nxt;
  logic                 start_nxt, rv_nxt, err_nxt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
    .clk(clk), .rst(rst), .btn(btn_enter), .press(enter_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk(clk), .rst(rst), .btn(btn_clear), .press(clear_p)
  );

`ifdef CALC_CHAIN_EN
  logic chain_fit;
  assign chain_fit = !sign && (result[RESULT_W-1:OPERAND_W] == '0);
`else
  logic unused_ok;
  assign unused_ok = ^{sign, result};
`endif

  assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign state_code = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_A;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear_p) begin
      state_nxt = S_A;
    end else begin
      case (state)
        S_A:    if (enter_p) state_nxt = S_B;
        S_B:    if (enter_p) state_nxt = S_OP;
        S_OP:   if (enter_p) state_nxt = S_CALC;
        S_CALC: if (calc_done || tmo_hit) state_nxt = S_SHOW;
        S_SHOW: begin
          if (enter_p) begin
            state_nxt = S_A;
`ifdef CALC_CHAIN_EN
            if (result_valid && !calc_error && chain_fit) state_nxt = S_B;
`endif
          end
        end
        default: state_nxt = S_A;
      endcase
    end
  end

  always_comb begin
    a_nxt     = operand_a;
    b_nxt     = operand_b;
    op_nxt    = operator;
    rv_nxt    = result_valid;
    err_nxt   = calc_error;
    start_nxt = 1'b0;
    if (clear_p) begin
      a_nxt   = '0;
      b_nxt   = '0;
      op_nxt  = OP_ADD;
      rv_nxt  = 1'b0;
      err_nxt = 1'b0;
    end else begin
      case (state)
        S_A:  if (enter_p) a_nxt = sw_data;
        S_B:  if (enter_p) b_nxt = sw_data;
        S_OP: begin
          if (enter_p) begin
            op_nxt    = sw_data[1:0];
            start_nxt = 1'b1;
          end
        end
        // A completion arriving on the timeout cycle still counts as success.
        S_CALC: begin
          if (calc_done)    rv_nxt  = 1'b1;
          else if (tmo_hit) err_nxt = 1'b1;
        end
        S_SHOW: begin
          if (enter_p) begin
            rv_nxt  = 1'b0;
            err_nxt = 1'b0;
`ifdef CALC_CHAIN_EN
            if (result_valid && !calc_error) begin
              if (chain_fit) a_nxt   = result[OPERAND_W-1:0];
              else           err_nxt = 1'b1;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      operand_a    <= '0;
      operand_b    <= '0;
      operator     <= OP_ADD;
      calc_start   <= 1'b0;
      result_valid <= 1'b0;
      calc_error   <= 1'b0;
    end else begin
      operand_a    <= a_nxt;
      operand_b    <= b_nxt;
      operator     <= op_nxt;
      calc_start   <= start_nxt;
      result_valid <= rv_nxt;
      calc_error   <= err_nxt;
    end
  end

  // The counter only runs while staying in S_CALC, so it reads zero on every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state == S_CALC && state_nxt == S_CALC) begin
      if (!tmo_hit) tmo_cnt <= tmo_cnt + TW'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

endmodule
